// File: rtl/snake_cmd_decoder.sv
// PS/2 scancode to snake game command decoder: make/break/E0 parser, start/pause pulses, direction FIFO.
// Optional SNAKE_ARROW_KEYS_EN maps extended arrow codes to directions; otherwise only WASD steers.
module snake_cmd_decoder #(
  parameter int         DEPTH    = 4,
  parameter logic [1:0] INIT_DIR = 2'd1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               key,
  input  logic                     key_pressed,
  input  logic                     step,
  output logic [1:0]               snake_dir,
  output logic                     start,
  output logic                     pause,
  output logic [$clog2(DEPTH):0]   q_level
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  state_t state;

  logic [DEPTH-1:0][1:0] fifo;
  logic [PW-1:0]         head, tail;
  logic                  enter_held, space_held;

  logic       is_prefix, is_make, is_brk, is_ext;
  logic       dir_hit, push, pop;
  logic [1:0] dir_new, ref_dir;

  assign is_prefix = (key == 8'hE0) || (key == 8'hF0);
  assign is_make   = key_pressed && !is_prefix && (state == IDLE || state == EXT);
  assign is_brk    = key_pressed && (state == BRK || state == EXT_BRK);
  assign is_ext    = (state == EXT) || (state == EXT_BRK);

  always_comb begin
    dir_hit = 1'b0;
    dir_new = 2'd0;
    if (!is_ext) begin
      case (key)
        8'h1D: begin dir_hit = 1'b1; dir_new = 2'd0; end
        8'h23: begin dir_hit = 1'b1; dir_new = 2'd1; end
        8'h1B: begin dir_hit = 1'b1; dir_new = 2'd2; end
        8'h1C: begin dir_hit = 1'b1; dir_new = 2'd3; end
        default: ;
      endcase
    end
`ifdef SNAKE_ARROW_KEYS_EN
    else begin
      case (key)
        8'h75: begin dir_hit = 1'b1; dir_new = 2'd0; end
        8'h74: begin dir_hit = 1'b1; dir_new = 2'd1; end
        8'h72: begin dir_hit = 1'b1; dir_new = 2'd2; end
        8'h6B: begin dir_hit = 1'b1; dir_new = 2'd3; end
        default: ;
      endcase
    end
`endif
  end

  // Candidate direction is checked against the last queued one, or the live one when empty.
  assign ref_dir = (q_level != '0) ? fifo[tail - 1'b1] : snake_dir;
  assign pop     = step && (q_level != '0) && !start;
  assign push    = is_make && dir_hit && (dir_new != ref_dir) && (dir_new != (ref_dir ^ 2'b10))
                   && ((q_level != FULL) || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      fifo       <= '0;
      head       <= '0;
      tail       <= '0;
      q_level    <= '0;
      snake_dir  <= INIT_DIR;
      start      <= 1'b0;
      pause      <= 1'b0;
      enter_held <= 1'b0;
      space_held <= 1'b0;
    end else begin
      start <= 1'b0;
      pause <= 1'b0;
      if (key_pressed) begin
        case (state)
          IDLE:    state <= (key == 8'hE0) ? EXT : (key == 8'hF0) ? BRK : IDLE;
          EXT:     state <= (key == 8'hF0) ? EXT_BRK : (key == 8'hE0) ? EXT : IDLE;
          default: state <= IDLE;
        endcase
      end
      // Held flags suppress typematic repeats until the matching break code.
      if (is_make && !is_ext) begin
        if (key == 8'h5A) begin start <= !enter_held; enter_held <= 1'b1; end
        if (key == 8'h29) begin pause <= !space_held; space_held <= 1'b1; end
      end
      if (is_brk && !is_ext) begin
        if (key == 8'h5A) enter_held <= 1'b0;
        if (key == 8'h29) space_held <= 1'b0;
      end
      if (start) begin
        head      <= '0;
        tail      <= '0;
        q_level   <= '0;
        snake_dir <= INIT_DIR;
      end else begin
        if (push) begin
          fifo[tail] <= dir_new;
          tail       <= tail + 1'b1;
        end
        if (pop) begin
          snake_dir <= fifo[head];
          head      <= head + 1'b1;
        end
        if (push && !pop)      q_level <= q_level + 1'b1;
        else if (pop && !push) q_level <= q_level - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_snake_cmd_decoder.sv
// Scoreboard bench for snake_cmd_decoder: pulse timing queues, direction queue, occupancy checks.
module tb_snake_cmd_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] key = 8'h00;
  logic       key_pressed = 1'b0;
  logic       step = 1'b0;
  logic [1:0] snake_dir;
  logic       start, pause;
  logic [2:0] q_level;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int start_exp[$], start_got[$], pause_exp[$], pause_got[$];
  logic [1:0] dir_exp[$];

  snake_cmd_decoder #(.DEPTH(4), .INIT_DIR(2'd1)) dut (
    .clk(clk), .rst(rst), .key(key), .key_pressed(key_pressed), .step(step),
    .snake_dir(snake_dir), .start(start), .pause(pause), .q_level(q_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (start) start_got.push_back(cyc);
    if (pause) pause_got.push_back(cyc);
  end

  task automatic send(input logic [7:0] b, input logic stp, input logic es, input logic ep);
    @(negedge clk);
    key = b; key_pressed = 1'b1; step = stp;
    if (es) start_exp.push_back(cyc + 1);
    if (ep) pause_exp.push_back(cyc + 1);
    @(negedge clk);
    key_pressed = 1'b0; step = 1'b0;
  endtask

  task automatic go_init();
    send(8'h5A, 0, 1, 0);
    send(8'hF0, 0, 0, 0);
    send(8'h5A, 0, 0, 0);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++; if (snake_dir !== 2'd1) begin fails++; $display("FAIL reset_dir got %0d exp 1", snake_dir); end
    tests++; if (q_level !== 3'd0) begin fails++; $display("FAIL reset_q got %0d exp 0", q_level); end
    tests++; if ({start, pause} !== 2'b00) begin fails++; $display("FAIL reset_pulses got %b exp 00", {start, pause}); end
    send(8'h1B, 0, 0, 0);
    send(8'hE0, 0, 0, 0);
    @(negedge clk); rst = 1'b0; #1;
    tests++; if (q_level !== 3'd0 || snake_dir !== 2'd1) begin
      fails++; $display("FAIL midseq_reset got q=%0d dir=%0d exp q=0 dir=1", q_level, snake_dir); end
    @(negedge clk); rst = 1'b1;
    send(8'h1D, 0, 0, 0);
    tests++; if (q_level !== 3'd1) begin fails++; $display("FAIL reset_idle_parse got q=%0d exp 1", q_level); end
  endtask

  task automatic test_start();
    send(8'h5A, 0, 1, 0);
    send(8'h5A, 0, 0, 0);
    send(8'h5A, 0, 0, 0);
    send(8'hF0, 0, 0, 0);
    send(8'h5A, 0, 0, 0);
    send(8'h5A, 0, 1, 0);
    tests++; if (q_level !== 3'd0) begin fails++; $display("FAIL start_flush got q=%0d exp 0", q_level); end
    send(8'hF0, 0, 0, 0);
    send(8'h5A, 0, 0, 0);
    send(8'hE0, 0, 0, 0);
    send(8'h5A, 0, 0, 0);
    send(8'hE0, 0, 0, 0);
    send(8'hF0, 0, 0, 0);
    send(8'h5A, 0, 0, 0);
  endtask

  task automatic test_pause();
    send(8'h29, 0, 0, 1);
    send(8'h29, 0, 0, 0);
    send(8'hF0, 0, 0, 0);
    send(8'h29, 0, 0, 0);
    send(8'h29, 0, 0, 1);
    send(8'hF0, 0, 0, 0);
    send(8'h29, 0, 0, 0);
  endtask

  task automatic test_dir_filter();
    go_init();
    send(8'h1D, 0, 0, 0);
    send(8'h1C, 0, 0, 0);
    send(8'h1C, 0, 0, 0);
    send(8'h23, 0, 0, 0);
    tests++; if (q_level !== 3'd2) begin fails++; $display("FAIL filter_q got %0d exp 2", q_level); end
    dir_exp.push_back(2'd0);
    dir_exp.push_back(2'd3);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
      tests++; if (snake_dir !== dir_exp[0]) begin
        fails++; $display("FAIL filter_step%0d got %0d exp %0d", i, snake_dir, dir_exp[0]); end
      void'(dir_exp.pop_front());
    end
  endtask

  task automatic test_reject();
    go_init();
    send(8'h1C, 0, 0, 0);
    tests++; if (q_level !== 3'd0) begin fails++; $display("FAIL reversal_q got %0d exp 0", q_level); end
    send(8'h1B, 0, 0, 0);
    tests++; if (q_level !== 3'd1) begin fails++; $display("FAIL accept_q got %0d exp 1", q_level); end
    go_init();
    send(8'h1B, 1, 0, 0);
    tests++; if (q_level !== 3'd1 || snake_dir !== 2'd1) begin
      fails++; $display("FAIL empty_pushpop got q=%0d dir=%0d exp q=1 dir=1", q_level, snake_dir); end
  endtask

  task automatic test_full();
    go_init();
    send(8'h1D, 0, 0, 0);
    send(8'h1C, 0, 0, 0);
    send(8'h1B, 0, 0, 0);
    send(8'h23, 0, 0, 0);
    tests++; if (q_level !== 3'd4) begin fails++; $display("FAIL fill_q got %0d exp 4", q_level); end
    send(8'h1D, 0, 0, 0);
    tests++; if (q_level !== 3'd4) begin fails++; $display("FAIL full_drop got %0d exp 4", q_level); end
    send(8'h1D, 1, 0, 0);
    tests++; if (q_level !== 3'd4 || snake_dir !== 2'd0) begin
      fails++; $display("FAIL full_pushpop got q=%0d dir=%0d exp q=4 dir=0", q_level, snake_dir); end
    dir_exp.push_back(2'd3); dir_exp.push_back(2'd2);
    dir_exp.push_back(2'd1); dir_exp.push_back(2'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
      tests++; if (snake_dir !== dir_exp[0]) begin
        fails++; $display("FAIL drain_step%0d got %0d exp %0d", i, snake_dir, dir_exp[0]); end
      void'(dir_exp.pop_front());
    end
    tests++; if (q_level !== 3'd0) begin fails++; $display("FAIL drain_q got %0d exp 0", q_level); end
  endtask

  task automatic test_start_step();
    send(8'h1B, 0, 0, 0);
    @(negedge clk);
    key = 8'h5A; key_pressed = 1'b1;
    start_exp.push_back(cyc + 1);
    @(negedge clk);
    key_pressed = 1'b0; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    tests++; if (snake_dir !== 2'd1 || q_level !== 3'd0) begin
      fails++; $display("FAIL start_step got dir=%0d q=%0d exp dir=1 q=0", snake_dir, q_level); end
    send(8'hF0, 0, 0, 0);
    send(8'h5A, 0, 0, 0);
  endtask

  task automatic test_arrows();
    logic [2:0] exp_q;
`ifdef SNAKE_ARROW_KEYS_EN
    exp_q = 3'd1;
`else
    exp_q = 3'd0;
`endif
    go_init();
    send(8'hE0, 0, 0, 0);
    send(8'h75, 0, 0, 0);
    tests++; if (q_level !== exp_q) begin fails++; $display("FAIL ext_up got q=%0d exp %0d", q_level, exp_q); end
    go_init();
    send(8'hE0, 0, 0, 0);
    send(8'hF0, 0, 0, 0);
    send(8'h75, 0, 0, 0);
    tests++; if (q_level !== 3'd0) begin fails++; $display("FAIL ext_break got q=%0d exp 0", q_level); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_pause();
    test_dir_filter();
    test_reject();
    test_full();
    test_start_step();
    test_arrows();
    repeat (2) @(negedge clk);
    tests++; if (start_got.size() != start_exp.size()) begin
      fails++; $display("FAIL start_count got %0d exp %0d", start_got.size(), start_exp.size()); end
    while (start_got.size() > 0 && start_exp.size() > 0) begin
      tests++; if (start_got[0] != start_exp[0]) begin
        fails++; $display("FAIL start_cycle got %0d exp %0d", start_got[0], start_exp[0]); end
      void'(start_got.pop_front()); void'(start_exp.pop_front());
    end
    tests++; if (pause_got.size() != pause_exp.size()) begin
      fails++; $display("FAIL pause_count got %0d exp %0d", pause_got.size(), pause_exp.size()); end
    while (pause_got.size() > 0 && pause_exp.size() > 0) begin
      tests++; if (pause_got[0] != pause_exp[0]) begin
        fails++; $display("FAIL pause_cycle got %0d exp %0d", pause_got[0], pause_exp[0]); end
      void'(pause_got.pop_front()); void'(pause_exp.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
